// File: rtl/uart_bridge_if.sv
// Core-side bus of the UART bridge: the send/receive handshake plus status flags.
interface uart_bridge_if;
  logic       sendingChar;
  logic [7:0] sendedChar;
  logic       receivingChar;
  logic [7:0] receivedChar;
  logic       charTaken;
  logic       txFull;
  logic       txOverflow;
  logic       rxOverrun;
  logic       rxFrameErr;

  // The core drives the requests and reads status.
  modport master (
    output sendingChar, sendedChar, charTaken,
    input  receivingChar, receivedChar, txFull, txOverflow, rxOverrun, rxFrameErr
  );

  // The bridge accepts the requests and reports status.
  modport slave (
    input  sendingChar, sendedChar, charTaken,
    output receivingChar, receivedChar, txFull, txOverflow, rxOverrun, rxFrameErr
  );
endinterface

// File: rtl/uart_bridge.sv
// UART bridge: 8N1 transmitter fed by a small FIFO, and an 8N1 receiver with
// a one-byte holding register toward the core. Sticky error flags clear on reset.
module uart_bridge #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_ADDR   = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_bridge_if.slave  bus,
  output logic          tx,
  input  logic          rx
);

  localparam int DEPTH = 1 << FIFO_ADDR;
  localparam int CW    = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [FIFO_ADDR:0] PTR_ONE = (FIFO_ADDR + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       fifo_mem [DEPTH];
  logic [FIFO_ADDR:0] wr_ptr;
  logic [FIFO_ADDR:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             tx_pop;
  logic             tx_overflow_r;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_ADDR] != rd_ptr[FIFO_ADDR]) &&
                      (wr_ptr[FIFO_ADDR-1:0] == rd_ptr[FIFO_ADDR-1:0]);
  assign push       = bus.sendingChar && !fifo_full;

  // Storage array; written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_ADDR-1:0]] <= bus.sendedChar;
  end

  // Pointer bookkeeping; a push into a full FIFO is lost and flagged even if a pop happens too.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_overflow_r <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (bus.sendingChar && fifo_full) tx_overflow_r <= 1'b1;
    end
  end

  assign bus.txFull     = fifo_full;
  assign bus.txOverflow = tx_overflow_r;

  // ---------------------------------------------------------------- TX FSM
  uart_state_t   tx_state;
  uart_state_t   tx_state_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_byte;
  logic          tx_bit_end;
  logic          tx_line_next;

  assign tx_bit_end = (tx_cnt == CNT_LAST);

  // TX state register.
  always_ff @(posedge clk) begin
    if (reset) tx_state <= ST_IDLE;
    else       tx_state <= tx_state_next;
  end

  // TX next state; STOP chains straight into START when more bytes wait, keeping frames gapless.
  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      ST_IDLE:  if (!fifo_empty) tx_state_next = ST_START;
      ST_START: if (tx_bit_end) tx_state_next = ST_DATA;
      ST_DATA:  if (tx_bit_end && (tx_idx == 3'd7)) tx_state_next = ST_STOP;
      ST_STOP:  if (tx_bit_end) tx_state_next = fifo_empty ? ST_IDLE : ST_START;
      default:  tx_state_next = ST_IDLE;
    endcase
  end

  // TX outputs: line level for the current bit and the FIFO pop request.
  always_comb begin
    tx_line_next = 1'b1;
    tx_pop       = 1'b0;
    case (tx_state)
      ST_IDLE:  tx_pop = !fifo_empty;
      ST_START: tx_line_next = 1'b0;
      ST_DATA:  tx_line_next = tx_byte[tx_idx];
      ST_STOP:  tx_pop = tx_bit_end && !fifo_empty;
      default:  tx_line_next = 1'b1;
    endcase
  end

  // TX datapath: bit timing counter, bit index, latched byte and the registered line.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_byte <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= tx_line_next;
      if (tx_pop) begin
        tx_byte <= fifo_mem[rd_ptr[FIFO_ADDR-1:0]];
        tx_cnt  <= '0;
        tx_idx  <= '0;
      end else if (tx_state != ST_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_state == ST_DATA) tx_idx <= tx_idx + 3'd1;
        end else begin
          tx_cnt <= tx_cnt + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX side
  logic          rx_meta;
  logic          rx_sync;
  uart_state_t   rx_state;
  uart_state_t   rx_state_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_cnt_clear;
  logic          rx_sample_data;
  logic          frame_done;
  logic          frame_bad;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_overrun_r;
  logic          rx_frame_err_r;

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset) rx_state <= ST_IDLE;
    else       rx_state <= rx_state_next;
  end

  // RX next state; a start bit that is high again at mid-bit is treated as a glitch.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      ST_IDLE:  if (!rx_sync) rx_state_next = ST_START;
      ST_START: if (rx_cnt == CNT_HALF) rx_state_next = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:  if ((rx_cnt == CNT_LAST) && (rx_idx == 3'd7)) rx_state_next = ST_STOP;
      ST_STOP:  if (rx_cnt == CNT_LAST) rx_state_next = ST_IDLE;
      default:  rx_state_next = ST_IDLE;
    endcase
  end

  // RX outputs: counter restart, data sample strobe and end-of-frame verdicts.
  always_comb begin
    rx_cnt_clear   = 1'b0;
    rx_sample_data = 1'b0;
    frame_done     = 1'b0;
    frame_bad      = 1'b0;
    case (rx_state)
      ST_IDLE:  rx_cnt_clear = 1'b1;
      ST_START: rx_cnt_clear = (rx_cnt == CNT_HALF);
      ST_DATA: begin
        rx_cnt_clear   = (rx_cnt == CNT_LAST);
        rx_sample_data = (rx_cnt == CNT_LAST);
      end
      ST_STOP: begin
        rx_cnt_clear = (rx_cnt == CNT_LAST);
        frame_done   = (rx_cnt == CNT_LAST) && rx_sync;
        frame_bad    = (rx_cnt == CNT_LAST) && !rx_sync;
      end
      default:  rx_cnt_clear = 1'b1;
    endcase
  end

  // RX datapath: sample-point counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt <= rx_cnt_clear ? '0 : rx_cnt + CNT_ONE;
      if (rx_state == ST_IDLE) rx_idx <= '0;
      if (rx_sample_data) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
    end
  end

  // Holding register toward the core; a consume in the completion cycle makes room for the new byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid       <= 1'b0;
      rx_data        <= '0;
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      if (frame_done) begin
        if (!rx_valid || bus.charTaken) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun_r <= 1'b1;
        end
      end else if (bus.charTaken && rx_valid) begin
        rx_valid <= 1'b0;
      end
      if (frame_bad) rx_frame_err_r <= 1'b1;
    end
  end

  assign bus.receivingChar = rx_valid;
  assign bus.receivedChar  = rx_data;
  assign bus.rxOverrun     = rx_overrun_r;
  assign bus.rxFrameErr    = rx_frame_err_r;

endmodule

// File: tb/tb_uart_bridge.sv
// Self-checking bench for uart_bridge with CLK_PER_BIT=4, FIFO_ADDR=2.
// TX is compared every cycle against a frame-level model; RX is checked per frame.
module tb_uart_bridge;
  localparam int CPB   = 4;
  localparam int FA    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;

  uart_bridge_if bus();

  uart_bridge #(.CLK_PER_BIT(CPB), .FIFO_ADDR(FA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .rx    (rx)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // ------------------------------------------------------------ TX reference model
  // The transmitter takes the oldest queued byte at the first edge at or after the
  // previous frame's end; the line shows that frame one cycle later for 10 bit times.
  byte unsigned m_q[$];
  int           free_at   = 0;
  int           cur_start = -1000;
  logic [7:0]   cur_byte  = 8'h00;
  logic         m_overflow = 1'b0;
  logic         was_full;
  logic         do_pop;

  // Model update on every clock edge from the bench's own stimulus.
  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      m_q.delete();
      free_at    = cycle + 1;
      cur_start  = -1000;
      m_overflow = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      do_pop   = (cycle >= free_at) && (m_q.size() > 0);
      if (do_pop) begin
        cur_byte  = m_q.pop_front();
        cur_start = cycle;
        free_at   = cycle + FRAME;
      end
      if (bus.sendingChar) begin
        if (was_full) m_overflow = 1'b1;
        else          m_q.push_back(bus.sendedChar);
      end
    end
  end

  function automatic logic expTx();
    int j;
    int b;
    j = cycle - (cur_start + 1);
    if (j < 0 || j >= FRAME) return 1'b1;
    b = j / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_byte[b-1];
  endfunction

  // Continuous TX-side comparison, sampled on the falling edge.
  always @(negedge clk) begin
    checkOutput("tx_line", tx, expTx());
    checkOutput("txFull", bus.txFull, (m_q.size() == DEPTH));
    checkOutput("txOverflow", bus.txOverflow, m_overflow);
  end

  // ------------------------------------------------------------ RX reference model
  logic       m_valid   = 1'b0;
  logic [7:0] m_data    = 8'h00;
  logic       m_overrun = 1'b0;
  logic       m_ferr    = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkRx(input string tag);
    checkOutput({tag, "_receivingChar"}, bus.receivingChar, m_valid);
    checkOutput({tag, "_receivedChar"}, bus.receivedChar, m_data);
    checkOutput({tag, "_rxOverrun"}, bus.rxOverrun, m_overrun);
    checkOutput({tag, "_rxFrameErr"}, bus.rxFrameErr, m_ferr);
  endtask

  task automatic doReset();
    reset = 1'b1;
    rx    = 1'b1;
    tick(1);
    reset     = 1'b0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_overrun = 1'b0;
    m_ferr    = 1'b0;
  endtask

  task automatic sendChar(input logic [7:0] b);
    bus.sendingChar = 1'b1;
    bus.sendedChar  = b;
    tick(1);
    bus.sendingChar = 1'b0;
  endtask

  task automatic takeChar();
    bus.charTaken = 1'b1;
    tick(1);
    bus.charTaken = 1'b0;
    if (m_valid) m_valid = 1'b0;
  endtask

  // Drive one 8N1 frame on rx, optionally consuming the held byte in the completion
  // cycle (two synchronizer edges, START entry, half-bit and 9 bit times after the start edge).
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic take_at_done);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    bus.charTaken = take_at_done;
    tick(1);
    bus.charTaken = 1'b0;
    if (stop_bit) begin
      if (!m_valid || take_at_done) begin
        m_data  = data;
        m_valid = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
      if (take_at_done) m_valid = 1'b0;
    end
    tick(2);
    checkRx("rx_frame");
    tick(2);
  endtask

  task automatic waitTxDrain();
    for (int i = 0; i < 4000 && !(m_q.size() == 0 && cycle >= free_at); i++) @(posedge clk);
    #1;
    tick(2);
  endtask

  // Watchdog so the run always ends even if the flow stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [9:0] frame_bits;

  // Main directed-then-random sequence.
  initial begin
    reset           = 1'b1;
    rx              = 1'b1;
    bus.sendingChar = 1'b0;
    bus.sendedChar  = 8'h00;
    bus.charTaken   = 1'b0;
    tick(2);
    reset = 1'b0;

    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_txFull", bus.txFull, 1'b0);
    checkOutput("reset_txOverflow", bus.txOverflow, 1'b0);
    checkOutput("reset_receivingChar", bus.receivingChar, 1'b0);
    checkOutput("reset_receivedChar", bus.receivedChar, 8'h00);
    checkOutput("reset_rxOverrun", bus.rxOverrun, 1'b0);
    checkOutput("reset_rxFrameErr", bus.rxFrameErr, 1'b0);
    tick(3);

    // Single byte 0x41: start bit two edges after the push, 40-cycle frame.
    frame_bits = {1'b1, 8'h41, 1'b0};
    sendChar(8'h41);
    tick(1);
    for (int j = 0; j < FRAME; j++) begin
      tick(1);
      checkOutput("frame41_bit", tx, frame_bits[j / CPB]);
    end
    tick(1);
    checkOutput("frame41_idle", tx, 1'b1);
    tick(3);

    // Six pushes on consecutive cycles into a 4-deep FIFO.
    for (int k = 1; k <= 6; k++) begin
      bus.sendingChar = 1'b1;
      bus.sendedChar  = 8'(k);
      tick(1);
    end
    bus.sendingChar = 1'b0;
    checkOutput("burst_txFull", bus.txFull, 1'b1);
    checkOutput("burst_txOverflow", bus.txOverflow, 1'b1);
    waitTxDrain();
    checkOutput("burst_drained_txFull", bus.txFull, 1'b0);
    checkOutput("burst_sticky_overflow", bus.txOverflow, 1'b1);

    // RX: single frame then consume.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("rxA5_data", bus.receivedChar, 8'hA5);
    takeChar();
    checkOutput("rxA5_taken", bus.receivingChar, 1'b0);
    checkOutput("rxA5_data_kept", bus.receivedChar, 8'hA5);
    takeChar();
    checkRx("take_when_empty");

    // Overrun: second frame with the first still unconsumed.
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    checkOutput("overrun_data", bus.receivedChar, 8'h11);
    checkOutput("overrun_flag", bus.rxOverrun, 1'b1);

    // Same again with the consume coincident with frame 2 completion.
    doReset();
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b1);
    checkOutput("coincident_data", bus.receivedChar, 8'h22);
    checkOutput("coincident_valid", bus.receivingChar, 1'b1);
    checkOutput("coincident_no_overrun", bus.rxOverrun, 1'b0);
    takeChar();

    // One-cycle glitch then a frame with a low stop bit.
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(3 * CPB);
    checkRx("glitch");
    applyStimulus(8'h33, 1'b0, 1'b0);
    checkOutput("ferr_valid", bus.receivingChar, 1'b0);
    checkOutput("ferr_flag", bus.rxFrameErr, 1'b1);

    // Reset in the middle of a TX data bit 3 with the FIFO full and an RX frame in flight.
    doReset();
    sendChar(8'h5A);
    rx = 1'b0;
    for (int k = 0; k < 4; k++) sendChar(8'hC0 + 8'(k));
    tick(13);
    reset = 1'b1;
    rx    = 1'b1;
    tick(1);
    reset = 1'b0;
    m_valid = 1'b0; m_data = 8'h00; m_overrun = 1'b0; m_ferr = 1'b0;
    checkOutput("midreset_tx", tx, 1'b1);
    checkOutput("midreset_txFull", bus.txFull, 1'b0);
    tick(2 * FRAME);
    checkOutput("midreset_tx_quiet", tx, 1'b1);
    checkRx("midreset_rx");

    // Randomized traffic on both directions.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        sendChar(8'($urandom_range(0, 255)));
        tick($urandom_range(0, 3));
      end
      for (int f = 0; f < 3; f++) begin
        applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) begin
          takeChar();
          checkRx("rand_take");
        end
      end
      if ($urandom_range(0, 2) == 0) waitTxDrain();
    end
    waitTxDrain();
    checkRx("final_rx");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
